// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefDepth = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrain
    } fetch_state_e;

    // Queue entry layout at default widths; the top declares the same shape at its own widths.
    typedef struct packed {
        logic [DefAddrW-1:0] pc;
        logic [DefDataW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush used as the fetch prefetch queue.
module fetch_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             full, empty;
    logic             do_push, do_pop;

    always_comb begin
        full    = (count_q == (PtrW + 1)'(Depth));
        empty   = (count_q == '0);
        do_pop  = pop_i && !empty;
        // A pop frees the slot in the same edge, so push-while-full is legal when popping.
        do_push = push_i && (!full || do_pop);
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PtrW'(1);
            if (do_pop)  rptr_d = rptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PtrW + 1)'(1);
                2'b01:   count_d = count_q - (PtrW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: owns the fetch PC, issues one ROM request at a time and queues {pc, instr}
// pairs for decode; a redirect flushes the queue and drains any in-flight request.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned      DataW   = DefDataW,
    parameter int unsigned      AddrW   = DefAddrW,
    parameter int unsigned      Depth   = DefDepth,
    parameter int unsigned      PcStep  = 1,
    parameter logic [AddrW-1:0] ResetPc = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             mem_req_o,
    output logic [AddrW-1:0] mem_addr_o,
    input  logic             mem_ack_i,
    input  logic [DataW-1:0] mem_rdata_i,
    output logic             dec_valid_o,
    output logic [DataW-1:0] dec_data_o,
    output logic [AddrW-1:0] dec_pc_o,
    input  logic             dec_ready_i,
    input  logic             redirect_valid_i,
    input  logic [AddrW-1:0] redirect_pc_i,
    output logic [AddrW-1:0] pc_next_o
);

    localparam int unsigned CntW = $clog2(Depth) + 1;

    typedef struct packed {
        logic [AddrW-1:0] pc;
        logic [DataW-1:0] instr;
    } entry_t;

    fetch_state_e     state_q, state_d;
    logic [AddrW-1:0] pc_q, pc_d;
    logic [AddrW-1:0] req_addr_q, req_addr_d;
    logic [CntW-1:0]  count;
    logic             issue, push, pop;
    entry_t           wentry, rentry;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (issue) state_d = StWait;
            end
            StWait: begin
                // An ack coinciding with a redirect closes the request; its data is dropped.
                if (mem_ack_i)             state_d = StIdle;
                else if (redirect_valid_i) state_d = StDrain;
            end
            StDrain: begin
                if (mem_ack_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and handshake decode
    always_comb begin
        // Only IDLE issues, so the in-flight term of the space check is always zero here.
        issue       = (state_q == StIdle) && !redirect_valid_i && (count < CntW'(Depth));
        mem_req_o   = (state_q == StWait) || (state_q == StDrain);
        mem_addr_o  = req_addr_q;
        push        = (state_q == StWait) && mem_ack_i && !redirect_valid_i;
        dec_valid_o = (count != '0);
        pop         = dec_valid_o && dec_ready_i && !redirect_valid_i;
        wentry      = '{pc: req_addr_q, instr: mem_rdata_i};
        dec_pc_o    = rentry.pc;
        dec_data_o  = rentry.instr;
        pc_next_o   = pc_q;
    end

    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (push) begin
            pc_d = pc_q + AddrW'(PcStep);
        end
        if (issue) req_addr_d = pc_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q       <= ResetPc;
            req_addr_q <= ResetPc;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_fifo #(
        .Depth (Depth),
        .Width (AddrW + DataW)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_valid_i),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (rentry),
        .count_o (count)
    );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a latency-programmable ROM model (mem[a] = a + 0x100).
module tb_fetch_prefetch;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        dec_valid;
    logic [31:0] dec_data;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_next;

    int checks;
    int failures;
    int rom_lat;
    int wait_cnt;

    fetch_prefetch dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .mem_req_o        (mem_req),
        .mem_addr_o       (mem_addr),
        .mem_ack_i        (mem_ack),
        .mem_rdata_i      (mem_rdata),
        .dec_valid_o      (dec_valid),
        .dec_data_o       (dec_data),
        .dec_pc_o         (dec_pc),
        .dec_ready_i      (dec_ready),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .pc_next_o        (pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: acks after rom_lat cycles of continuous request; shares the reset.
    always_comb begin
        mem_ack   = mem_req && (wait_cnt >= rom_lat);
        mem_rdata = mem_addr + 32'h100;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 wait_cnt <= 0;
        else if (!mem_req || mem_ack) wait_cnt <= 0;
        else                        wait_cnt <= wait_cnt + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    int          acks;
    int          n;
    logic        ok;
    logic        seen;
    logic [31:0] first_addr;
    logic [31:0] ack_addr [2];
    logic [31:0] pcs [5];

    initial begin
        checks         = 0;
        failures       = 0;
        rom_lat        = 0;
        rst_n          = 1'b0;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values
        step();
        step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_dec_data", dec_data, 0);
        check("rst_dec_pc", dec_pc, 0);
        check("rst_pc_next", pc_next, 0);

        // 1: zero-wait ROM streaming, one instruction per 2 cycles
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t1_req", mem_req, 1);
            check("t1_addr", mem_addr, 64'(k));
            check("t1_valid_lo", dec_valid, 0);
            step();
            check("t1_valid", dec_valid, 1);
            check("t1_pc", dec_pc, 64'(k));
            check("t1_data", dec_data, 64'(k + 'h100));
            check("t1_req_lo", mem_req, 0);
        end

        // 2: backpressure fills the queue with exactly Depth entries
        dec_ready = 1'b0;
        do_reset();
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req && mem_ack) acks++;
            step();
        end
        check("t2_req_count", acks, 4);
        check("t2_req_idle", mem_req, 0);
        check("t2_head_valid", dec_valid, 1);
        check("t2_head_pc", dec_pc, 0);
        dec_ready = 1'b1;
        n = 0;
        seen = 1'b0;
        first_addr = '1;
        for (int i = 0; i < 40 && n < 5; i++) begin
            if (mem_req && mem_ack && !seen) begin
                seen = 1'b1;
                first_addr = mem_addr;
            end
            if (dec_valid) begin
                pcs[n] = dec_pc;
                n++;
            end
            step();
        end
        check("t2_drained", n, 5);
        for (int i = 0; i < 5; i++) check("t2_pop_order", pcs[i], 64'(i));
        check("t2_resume_addr", first_addr, 4);

        // 3: redirect while waiting on a slow ROM drains the old request
        rom_lat = 3;
        do_reset();
        step();
        check("t3_wait_req", mem_req, 1);
        check("t3_wait_addr", mem_addr, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("t3_drain_req", mem_req, 1);
        check("t3_drain_addr", mem_addr, 0);
        check("t3_pc_next", pc_next, 32'h40);
        check("t3_no_valid", dec_valid, 0);
        acks = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dec_valid) begin
                ok = 1'b1;
                break;
            end
            if (mem_ack && acks < 2) begin
                ack_addr[acks] = mem_addr;
                acks++;
            end
            step();
        end
        check("t3_delivered", ok, 1);
        check("t3_ack_count", acks, 2);
        check("t3_drain_ack_addr", ack_addr[0], 0);
        check("t3_new_addr", ack_addr[1], 32'h40);
        check("t3_first_pc", dec_pc, 32'h40);
        check("t3_first_data", dec_data, 32'h140);

        // 4: redirect coincides with an ack and a pop while the queue holds 2
        rom_lat   = 0;
        dec_ready = 1'b0;
        do_reset();
        acks = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_ack) acks++;
            if (acks == 3) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("t4_setup", ok, 1);
        check("t4_head_pc", dec_pc, 0);
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        redirect_valid = 1'b0;
        check("t4_flushed", dec_valid, 0);
        check("t4_pc_next", pc_next, 32'h80);
        check("t4_req_idle", mem_req, 0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dec_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("t4_delivered", ok, 1);
        check("t4_first_pc", dec_pc, 32'h80);
        check("t4_first_data", dec_data, 32'h180);

        // 5: PC wraps from all-ones to zero
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        check("t5_pc_next", pc_next, 32'hFFFF_FFFF);
        acks = 0;
        for (int i = 0; i < 20 && acks < 2; i++) begin
            if (mem_ack) begin
                ack_addr[acks] = mem_addr;
                acks++;
            end
            step();
        end
        check("t5_ack_count", acks, 2);
        check("t5_addr_top", ack_addr[0], 32'hFFFF_FFFF);
        check("t5_addr_wrap", ack_addr[1], 0);

        // 6: asynchronous reset in the middle of a request
        rom_lat        = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req && mem_addr == 32'h200) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("t6_mid_wait", ok, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_req", mem_req, 0);
        check("t6_addr", mem_addr, 0);
        check("t6_valid", dec_valid, 0);
        check("t6_data", dec_data, 0);
        check("t6_pc_next", pc_next, 0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_restart_req", mem_req, 1);
        check("t6_restart_addr", mem_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
